// File: rtl/alu_op_seq.sv
// Operation sequencer for the team ALU: registers one request onto A/B/ALU_Sel, waits SETTLE_CYCLES, then
// captures the result behind a valid/ready response port. Define ALU_SEQ_SWEEP_EN to build the select-sweep mode.
module alu_op_seq #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic [3:0] req_sel,
  output logic [7:0] A,
  output logic [7:0] B,
  output logic [3:0] ALU_Sel,
  input  logic [7:0] ALU_Out,
  input  logic       CarryOut,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_carry,
  output logic       rsp_zero,
  output logic [7:0] op_count,
  input  logic       sweep_start,
  output logic       sweep_busy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready,
  // and once rsp_valid rises its payload holds until that transfer.
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic [3:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_carry_q, rsp_carry_d;
  logic       rsp_zero_q, rsp_zero_d;
  logic [7:0] op_count_q, op_count_d;
  logic       sweep_take;

`ifdef ALU_SEQ_SWEEP_EN
  logic       busy_q, busy_d;
  logic [3:0] idx_q, idx_d;

  assign sweep_take = sweep_start && (state_q == IDLE);
  assign sweep_busy = busy_q;
`else
  logic unused_sweep_start;

  assign unused_sweep_start = sweep_start;
  assign sweep_take         = 1'b0;
  assign sweep_busy         = 1'b0;
`endif

  assign req_ready = (state_q == IDLE) && !rst && !sweep_take;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_zero_d  = rsp_zero_q;
    op_count_d  = op_count_q;
`ifdef ALU_SEQ_SWEEP_EN
    busy_d      = busy_q;
    idx_d       = idx_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef ALU_SEQ_SWEEP_EN
        if (sweep_take) begin
          a_d     = req_a;
          b_d     = req_b;
          sel_d   = 4'd0;
          idx_d   = 4'd0;
          busy_d  = 1'b1;
          cnt_d   = 4'd0;
          state_d = SETTLE;
        end else
`endif
        if (req_valid && req_ready) begin
          a_d     = req_a;
          b_d     = req_b;
          sel_d   = req_sel;
          cnt_d   = 4'd0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) begin
          rsp_data_d  = ALU_Out;
          rsp_carry_d = CarryOut;
          rsp_zero_d  = (ALU_Out == 8'h00);
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 8'd1;
          state_d     = IDLE;
`ifdef ALU_SEQ_SWEEP_EN
          // A sweep re-enters SETTLE directly with the next select; operands stay latched.
          if (busy_q) begin
            if (idx_q == 4'hF) begin
              busy_d = 1'b0;
            end else begin
              idx_d   = idx_q + 4'd1;
              sel_d   = idx_q + 4'd1;
              cnt_d   = 4'd0;
              state_d = SETTLE;
            end
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      sel_q       <= 4'h0;
      cnt_q       <= 4'h0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_carry_q <= 1'b0;
      rsp_zero_q  <= 1'b0;
      op_count_q  <= 8'h00;
`ifdef ALU_SEQ_SWEEP_EN
      busy_q      <= 1'b0;
      idx_q       <= 4'h0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_zero_q  <= rsp_zero_d;
      op_count_q  <= op_count_d;
`ifdef ALU_SEQ_SWEEP_EN
      busy_q      <= busy_d;
      idx_q       <= idx_d;
`endif
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign ALU_Sel   = sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_zero  = rsp_zero_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_op_seq.sv
// Bench for alu_op_seq: a behavioural team ALU feeds two sequencers (SETTLE_CYCLES=1 and 4); responses
// from the first are checked by a queue-driven monitor.
module tb_alu_op_seq;

  localparam int W = 19; // {lat_chk, op_count_after, data, carry, zero}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst = 1'b1, req_valid = 1'b0, rsp_ready = 1'b1, sweep_start = 1'b0;
  logic [7:0] req_a = 8'h00, req_b = 8'h00;
  logic [3:0] req_sel = 4'h0;
  logic       req_ready, carry_out, rsp_valid, rsp_carry, rsp_zero, sweep_busy;
  logic [7:0] a_o, b_o, alu_out, rsp_data, op_count;
  logic [3:0] sel_o;

  logic       rst4 = 1'b1, req_valid4 = 1'b0, rsp_ready4 = 1'b1;
  logic       req_ready4, carry4, rsp_valid4, rsp_carry4, rsp_zero4, sweep_busy4;
  logic [7:0] a4, b4, alu_out4, rsp_data4, op_count4;
  logic [3:0] sel4;

  // Team ALU: carry is always the carry of A+B; divide by zero yields 8'hFF.
  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    logic [8:0]  s;
    logic [15:0] m;
    logic [7:0]  r;
    s = {1'b0, a} + {1'b0, b};
    m = a * b;
    case (sel)
      4'd0:  r = s[7:0];
      4'd1:  r = a - b;
      4'd2:  r = m[7:0];
      4'd3:  r = (b == 8'h00) ? 8'hFF : a / b;
      4'd4:  r = {a[6:0], 1'b0};
      4'd5:  r = {1'b0, a[7:1]};
      4'd6:  r = {a[6:0], a[7]};
      4'd7:  r = {a[0], a[7:1]};
      4'd8:  r = a & b;
      4'd9:  r = a | b;
      4'd10: r = a ^ b;
      4'd11: r = ~(a | b);
      4'd12: r = ~(a & b);
      4'd13: r = ~(a ^ b);
      4'd14: r = {7'd0, a > b};
      default: r = {7'd0, a == b};
    endcase
    return {s[8], r};
  endfunction

  assign {carry_out, alu_out} = alu_f(a_o, b_o, sel_o);
  assign {carry4, alu_out4}   = alu_f(a4, b4, sel4);

  alu_op_seq #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .A(a_o), .B(b_o), .ALU_Sel(sel_o), .ALU_Out(alu_out), .CarryOut(carry_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .op_count(op_count),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy)
  );

  alu_op_seq #(.SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst4), .req_valid(req_valid4), .req_ready(req_ready4),
    .req_a(8'h0A), .req_b(8'h02), .req_sel(4'h0),
    .A(a4), .B(b4), .ALU_Sel(sel4), .ALU_Out(alu_out4), .CarryOut(carry4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_data(rsp_data4),
    .rsp_carry(rsp_carry4), .rsp_zero(rsp_zero4), .op_count(op_count4),
    .sweep_start(1'b0), .sweep_busy(sweep_busy4)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  logic [7:0]   exp_cnt = 8'h00;
  logic [W-1:0] cur;
  bit           active  = 1'b0;
  bit           hs_pend = 1'b0;
  int           hs_count = 0;

  always begin
    @(negedge clk);
    #3;
    if (hs_pend) begin
      check("op_count", op_count, cur[17:10]);
      check("rsp_valid_drop", rsp_valid, 0);
      hs_pend = 1'b0;
      hs_count++;
    end
    if (rsp_valid) begin
      if (!active) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", rsp_valid, 0);
        end else begin
          int acc;
          cur    = exp_q.pop_front();
          active = 1'b1;
          check("rsp_data", rsp_data, cur[9:2]);
          check("rsp_carry", rsp_carry, cur[1]);
          check("rsp_zero", rsp_zero, cur[0]);
          if (cur[18] && acc_q.size() != 0) begin
            acc = acc_q.pop_front();
            check("latency", cyc + 1 - acc, 2);
          end
        end
      end else begin
        check("rsp_data_hold", rsp_data, cur[9:2]);
        check("rsp_carry_hold", rsp_carry, cur[1]);
      end
      if (active && rsp_ready) begin
        hs_pend = 1'b1;
        active  = 1'b0;
      end
    end
  end

  // Driver: present one request on dut and hold it until accepted.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                       input logic [7:0] ed, input logic ec);
    logic rdy;
    bit   done;
    exp_cnt = exp_cnt + 8'd1;
    exp_q.push_back({1'b1, exp_cnt, ed, ec, (ed == 8'h00)});
    @(negedge clk);
    req_a = a; req_b = b; req_sel = sel; req_valid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      #1 rdy = req_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        acc_q.push_back(cyc);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    check("req_accept", done, 1);
    if (!done) begin
      void'(exp_q.pop_back());
      exp_cnt = exp_cnt - 8'd1;
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || active || hs_pend) && n < budget) begin
      @(negedge clk);
      #4;
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    if (exp_q.size() != 0) begin
      exp_q.delete();
      acc_q.delete();
      active = 1'b0;
    end
  endtask

  bit rv4_seen = 1'b0;
  always @(negedge clk) if (rsp_valid4) rv4_seen = 1'b1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         hs0, n, acc;
    logic [8:0] res;
    logic [7:0] av, bv;
    logic [7:0] sw_exp[16];
    sw_exp = '{8'h0C, 8'h08, 8'h14, 8'h05, 8'h14, 8'h05, 8'h14, 8'h05,
               8'h02, 8'h0A, 8'h08, 8'hF5, 8'hFD, 8'hF7, 8'h01, 8'h00};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("ready_in_rst", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_op_count", op_count, 0);
    check("rst_A", a_o, 0);
    check("rst_sel", sel_o, 0);
    check("rst_sweep_busy", sweep_busy, 0);
    @(negedge clk);
    rst = 1'b0; rst4 = 1'b0;
    #1;
    check("ready_after_rst", req_ready, 1);
    check("ready4_after_rst", req_ready4, 1);

    // Directed vectors, consumer always ready
    issue(8'h0A, 8'h02, 4'd0, 8'h0C, 1'b0);
    issue(8'hF6, 8'h0A, 4'd0, 8'h00, 1'b1);
    issue(8'h0A, 8'h02, 4'd1, 8'h08, 1'b0);
    issue(8'h55, 8'h55, 4'd10, 8'h00, 1'b0);
    issue(8'h81, 8'h03, 4'd6, 8'h03, 1'b0);
    issue(8'hC8, 8'h64, 4'd5, 8'h64, 1'b1);
    drain(50);

`ifndef ALU_SEQ_SWEEP_EN
    // Sweep trigger must be inert in this build
    sweep_start = 1'b1;
    issue(8'h33, 8'h33, 4'd15, 8'h01, 1'b0);
    drain(50);
    sweep_start = 1'b0;
    check("no_sweep_busy", sweep_busy, 0);
`endif

    // Consumer stall
    rsp_ready = 1'b0;
    issue(8'hF0, 8'h3C, 4'd8, 8'h30, 1'b1);
    n = 0;
    #1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", rsp_valid, 1);
      check("stall_data", rsp_data, 8'h30);
      check("stall_ready", req_ready, 0);
      @(negedge clk);
      #1;
    end
    hs0 = hs_count;
    rsp_ready = 1'b1;
    @(negedge clk);
    #4;
    check("stall_valid_drop", rsp_valid, 0);
    check("stall_back_idle", req_ready, 1);
    check("stall_single_hs", hs_count - hs0, 1);
    @(negedge clk);
    #4;
    check("stall_no_second_hs", hs_count - hs0, 1);
    drain(20);

    // Reset in SETTLE on the SETTLE_CYCLES=4 instance
    @(negedge clk);
    req_valid4 = 1'b1;
    #1 check("ready4_idle", req_ready4, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid4 = 1'b0;
    @(negedge clk);
    rst4 = 1'b1;
    #1 check("ready4_in_rst", req_ready4, 0);
    @(negedge clk);
    rst4 = 1'b0;
    #1;
    check("ready4_after_mid_rst", req_ready4, 1);
    check("op_count4_after_rst", op_count4, 0);
    check("A4_after_rst", a4, 0);
    repeat (8) @(negedge clk);
    check("no_rsp4_after_rst", rv4_seen, 0);

    // SETTLE_CYCLES=4 latency and result
    @(negedge clk);
    req_valid4 = 1'b1;
    @(posedge clk);
    #1 acc = cyc;
    @(negedge clk);
    req_valid4 = 1'b0;
    n = 0;
    #1;
    while (!rsp_valid4 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("latency4", cyc + 1 - acc, 5);
    check("rsp_data4", rsp_data4, 8'h0C);
    @(negedge clk);
    #1 check("op_count4", op_count4, 1);

    // 256 completed operations wrap op_count to zero
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      av  = 8'(i);
      bv  = 8'(i * 7 + 3);
      res = alu_f(av, bv, av[3:0]);
      issue(av, bv, av[3:0], res[7:0], res[8]);
    end
    drain(50);
    check("op_count_wrap", op_count, 8'h00);

`ifdef ALU_SEQ_SWEEP_EN
    // Sweep with a competing request in the start cycle
    hs0 = hs_count;
    for (int s = 0; s < 16; s++) begin
      exp_cnt = exp_cnt + 8'd1;
      exp_q.push_back({1'b0, exp_cnt, sw_exp[s], 1'b0, (sw_exp[s] == 8'h00)});
    end
    @(negedge clk);
    sweep_start = 1'b1; req_valid = 1'b1;
    req_a = 8'h0A; req_b = 8'h02; req_sel = 4'd3;
    #1 check("sweep_prio_ready", req_ready, 0);
    @(posedge clk);
    #1;
    check("sweep_busy_start", sweep_busy, 1);
    check("sweep_sel0", sel_o, 0);
    check("sweep_A", a_o, 8'h0A);
    check("sweep_B", b_o, 8'h02);
    @(negedge clk);
    sweep_start = 1'b0; req_valid = 1'b0;
    n = 0;
    av = 8'h00;
    #4;
    while (sweep_busy && n < 400) begin
      if (req_ready) av = av + 8'd1;
      @(negedge clk);
      #4;
      n++;
    end
    check("sweep_busy_drop", sweep_busy, 0);
    check("sweep_hs_at_drop", hs_count - hs0, 16);
    check("sweep_ready_low", av, 0);
    repeat (4) @(negedge clk);
    #4;
    check("sweep_no_extra_rsp", rsp_valid, 0);
    check("sweep_hs_total", hs_count - hs0, 16);
    drain(10);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
